// File: rtl/icache_line_responder.sv
// icache_line_responder: two-bank direct-mapped I-cache returning lines L and L+1 per fetch, with miss refill and MMIO bypass.
// Optional ICACHE_PERF_CNT_EN adds saturating per-line hit/miss counters (perf_hits, perf_misses).
module icache_line_responder #(
   parameter int XLEN    = 32,
   parameter int CL_SIZE = 128,
   parameter int SETS    = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [XLEN-1:0]    req_pc,
   input  logic               req_pcd,
   input  logic               flush,
   input  logic               invalidate,
   output logic               rsp_valid,
   output logic [CL_SIZE-1:0] rsp_data_even,
   output logic [CL_SIZE-1:0] rsp_data_odd,
   output logic               rsp_even_hit,
   output logic               rsp_odd_hit,
   output logic               mem_req_valid,
   input  logic               mem_req_ready,
   output logic [XLEN-1:0]    mem_req_addr,
   input  logic               mem_rsp_valid,
   input  logic [CL_SIZE-1:0] mem_rsp_data
`ifdef ICACHE_PERF_CNT_EN
   ,
   output logic [31:0]        perf_hits,
   output logic [31:0]        perf_misses
`endif
);
   localparam int IDX = $clog2(SETS);
   localparam int TAG = XLEN - 5 - IDX;
   localparam int LW  = XLEN - 4;

   typedef enum logic [2:0] {IDLE, FILL_REQ, FILL_WAIT, UC_REQ, UC_WAIT} state_t;
   state_t state, state_nx;

   logic [CL_SIZE-1:0] data_arr [2][SETS];
   logic [TAG-1:0]     tag_arr  [2][SETS];
   logic [SETS-1:0]    valid    [2];
   logic [LW-1:0]      line, line_e, line_o, fill_line, odd_line;
   logic               odd_pend, drop, hit_e, hit_o, accept, uc_done, wr_en;
   logic               unused;

   assign line          = req_pc[XLEN-1:4];
   assign line_e        = line[0] ? line + LW'(1) : line;
   assign line_o        = line[0] ? line : line + LW'(1);
   assign hit_e         = valid[0][line_e[IDX:1]] && tag_arr[0][line_e[IDX:1]] == line_e[LW-1:IDX+1];
   assign hit_o         = valid[1][line_o[IDX:1]] && tag_arr[1][line_o[IDX:1]] == line_o[LW-1:IDX+1];
   assign req_ready     = state == IDLE;
   assign accept        = req_valid && req_ready;
   assign uc_done       = state == UC_WAIT && mem_rsp_valid;
   // a fill is discarded if invalidate was seen at any point while waiting for it
   assign wr_en         = state == FILL_WAIT && mem_rsp_valid && !drop && !invalidate;
   assign mem_req_valid = state == FILL_REQ || state == UC_REQ;
   assign mem_req_addr  = {fill_line, 4'b0};
   assign unused        = ^{req_pc[3:0], line_e[0], line_o[0]};

   // next-state: even line refills before odd, MMIO goes through the UC pair
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:             if (accept) state_nx = req_pcd ? UC_REQ : (hit_e && hit_o ? IDLE : FILL_REQ);
         FILL_REQ, UC_REQ: if (mem_req_ready) state_nx = state == FILL_REQ ? FILL_WAIT : UC_WAIT;
         FILL_WAIT:        if (mem_rsp_valid) state_nx = odd_pend ? FILL_REQ : IDLE;
         UC_WAIT:          if (mem_rsp_valid) state_nx = IDLE;
         default:          state_nx = IDLE;
      endcase
   end

   // state, valid bits, refill bookkeeping and registered response
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         valid[0]      <= '0;
         valid[1]      <= '0;
         odd_pend      <= 1'b0;
         drop          <= 1'b0;
         fill_line     <= '0;
         odd_line      <= '0;
         rsp_valid     <= 1'b0;
         rsp_data_even <= '0;
         rsp_data_odd  <= '0;
         rsp_even_hit  <= 1'b0;
         rsp_odd_hit   <= 1'b0;
      end else begin
         state     <= state_nx;
         drop      <= state == FILL_WAIT && !mem_rsp_valid && (drop || invalidate);
         rsp_valid <= !flush && ((accept && !req_pcd) || uc_done);
         if (invalidate) begin
            valid[0] <= '0;
            valid[1] <= '0;
         end else if (wr_en)
            valid[fill_line[0]][fill_line[IDX:1]] <= 1'b1;
         if (accept && !req_pcd) begin
            rsp_data_even <= data_arr[0][line_e[IDX:1]];
            rsp_data_odd  <= data_arr[1][line_o[IDX:1]];
            rsp_even_hit  <= hit_e;
            rsp_odd_hit   <= hit_o;
         end else if (uc_done) begin
            rsp_data_even <= fill_line[0] ? '0 : mem_rsp_data;
            rsp_data_odd  <= fill_line[0] ? mem_rsp_data : '0;
            rsp_even_hit  <= !fill_line[0];
            rsp_odd_hit   <= fill_line[0];
         end
         if (accept) begin
            fill_line <= req_pcd ? line : (hit_e ? line_o : line_e);
            odd_line  <= line_o;
            odd_pend  <= !req_pcd && !hit_e && !hit_o;
         end else if (state == FILL_WAIT && mem_rsp_valid && odd_pend) begin
            fill_line <= odd_line;
            odd_pend  <= 1'b0;
         end
      end
   end

   // line storage written on a surviving refill
   always_ff @(posedge clk) begin
      if (wr_en) begin
         data_arr[fill_line[0]][fill_line[IDX:1]] <= mem_rsp_data;
         tag_arr[fill_line[0]][fill_line[IDX:1]]  <= fill_line[LW-1:IDX+1];
      end
   end

`ifdef ICACHE_PERF_CNT_EN
   logic [32:0] hits_sum, miss_sum;
   assign hits_sum = {1'b0, perf_hits} + 33'(hit_e) + 33'(hit_o);
   assign miss_sum = {1'b0, perf_misses} + 33'(!hit_e) + 33'(!hit_o);

   // saturating per-line counters on every unflushed cached response
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_hits   <= '0;
         perf_misses <= '0;
      end else if (accept && !req_pcd && !flush) begin
         perf_hits   <= hits_sum[32] ? '1 : hits_sum[31:0];
         perf_misses <= miss_sum[32] ? '1 : miss_sum[31:0];
      end
   end
`endif
endmodule

// File: tb/tb_icache_line_responder.sv
// tb_icache_line_responder: scoreboard bench for icache_line_responder with a latency-configurable memory model.
module tb_icache_line_responder;
   logic         clk = 1'b0, rst = 1'b0;
   logic         req_valid = 1'b0, req_pcd = 1'b0, flush = 1'b0, invalidate = 1'b0;
   logic [31:0]  req_pc = '0;
   logic         req_ready, rsp_valid, rsp_even_hit, rsp_odd_hit;
   logic [127:0] rsp_data_even, rsp_data_odd;
   logic         mem_req_valid, mem_req_ready = 1'b1, mem_rsp_valid = 1'b0;
   logic [31:0]  mem_req_addr;
   logic [127:0] mem_rsp_data = '0;

   int checks = 0, errors = 0;

   typedef struct {
      logic         eh;
      logic         oh;
      logic [127:0] de;
      logic [127:0] dd;
   } exp_t;
   exp_t        sb[$];
   exp_t        mon_e;
   logic [31:0] got_addr[$];

   int          rsp_lat = 2, rsp_cnt = 0;
   bit          hold = 0, inject = 0, rsp_busy = 0;
   logic [31:0] rsp_addr = '0;

   always #5 clk = ~clk;

   icache_line_responder dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
      .req_pcd(req_pcd), .flush(flush), .invalidate(invalidate), .rsp_valid(rsp_valid),
      .rsp_data_even(rsp_data_even), .rsp_data_odd(rsp_data_odd), .rsp_even_hit(rsp_even_hit),
      .rsp_odd_hit(rsp_odd_hit), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
   );

   function automatic logic [127:0] mem_line(input logic [31:0] a);
      return {a, ~a, a ^ 32'hDEAD_BEEF, a + 32'h0123_4567};
   endfunction

   // memory: logs each accepted request, answers rsp_lat cycles later unless held
   always @(negedge clk) begin
      mem_rsp_valid = 1'b0;
      if (inject) begin
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = '1;
      end else if (rsp_busy) begin
         if (hold) rsp_busy = 0;
         else if (rsp_cnt == 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_line(rsp_addr);
            rsp_busy      = 0;
         end else rsp_cnt--;
      end
      if (mem_req_valid && mem_req_ready) begin
         got_addr.push_back(mem_req_addr);
         rsp_busy = 1;
         rsp_addr = mem_req_addr;
         rsp_cnt  = rsp_lat;
      end
   end

   // scoreboard: every response must match the oldest expectation
   always @(negedge clk) begin
      if (rsp_valid) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rsp got even_hit=%0b odd_hit=%0b expected no response", rsp_even_hit, rsp_odd_hit);
         end else begin
            mon_e = sb.pop_front();
            if ({rsp_even_hit, rsp_odd_hit} !== {mon_e.eh, mon_e.oh}) begin
               errors++;
               $display("FAIL rsp_hits got %b expected %b", {rsp_even_hit, rsp_odd_hit}, {mon_e.eh, mon_e.oh});
            end
            if (mon_e.eh) begin
               checks++;
               if (rsp_data_even !== mon_e.de) begin
                  errors++;
                  $display("FAIL rsp_data_even got %h expected %h", rsp_data_even, mon_e.de);
               end
            end
            if (mon_e.oh) begin
               checks++;
               if (rsp_data_odd !== mon_e.dd) begin
                  errors++;
                  $display("FAIL rsp_data_odd got %h expected %h", rsp_data_odd, mon_e.dd);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic fetch(input logic [31:0] pc, input bit pcd, input bit fl, input bit inv, input bit eh, input bit oh);
      logic [27:0] l, le, lo;
      exp_t e;
      int n;
      l  = pc[31:4];
      le = l[0] ? l + 28'd1 : l;
      lo = l[0] ? l : l + 28'd1;
      n  = 0;
      while (req_ready !== 1'b1 && n < 300) begin @(posedge clk); #1; n++; end
      if (req_ready !== 1'b1) begin
         checks++; errors++;
         $display("FAIL fetch_ready pc=%h got req_ready=%b expected 1", pc, req_ready);
      end
      if (pcd) e = '{!l[0], l[0], l[0] ? 128'h0 : mem_line({l, 4'h0}), l[0] ? mem_line({l, 4'h0}) : 128'h0};
      else     e = '{eh, oh, mem_line({le, 4'h0}), mem_line({lo, 4'h0})};
      if (!fl) sb.push_back(e);
      req_valid = 1'b1; req_pc = pc; req_pcd = pcd; flush = fl; invalidate = inv;
      @(posedge clk); #1;
      req_valid = 1'b0; req_pcd = 1'b0; flush = 1'b0; invalidate = 1'b0;
      checks++;
      if (rsp_valid !== (!pcd && !fl)) begin
         errors++;
         $display("FAIL rsp_timing pc=%h got rsp_valid=%b expected %b", pc, rsp_valid, !pcd && !fl);
      end
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      do begin @(posedge clk); #1; n++; end while (req_ready !== 1'b1 && n < 300);
      @(negedge clk); @(negedge clk);
      checks++;
      if (req_ready !== 1'b1 || sb.size() != 0) begin
         errors++;
         $display("FAIL %s_idle got req_ready=%b pending=%0d expected 1/0", name, req_ready, sb.size());
      end
   endtask

   task automatic wait_fill_wait(input string name);
      int n = 0;
      while (!(got_addr.size() == 1 && mem_req_valid === 1'b0) && n < 100) begin @(posedge clk); #1; n++; end
      checks++;
      if (got_addr.size() != 1 || mem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s_fill_wait got reqs=%0d mem_req_valid=%b expected 1/0", name, got_addr.size(), mem_req_valid);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({rsp_valid, mem_req_valid, req_ready} !== 3'b001) begin
         errors++;
         $display("FAIL reset_ctrl got %b expected 001", {rsp_valid, mem_req_valid, req_ready});
      end
      checks++;
      if (mem_req_addr !== 32'h0) begin
         errors++;
         $display("FAIL reset_addr got %h expected 0", mem_req_addr);
      end
      checks++;
      if ({rsp_data_even, rsp_data_odd, rsp_even_hit, rsp_odd_hit} !== '0) begin
         errors++;
         $display("FAIL reset_rsp got %h/%h/%b%b expected zeros", rsp_data_even, rsp_data_odd, rsp_even_hit, rsp_odd_hit);
      end
      rst = 1'b1;
   endtask

   task automatic test_cold_fill();
      got_addr.delete();
      fetch(32'h100, 0, 0, 0, 0, 0);
      wait_idle("cold");
      checks++;
      if (got_addr.size() != 2 || got_addr[0] !== 32'h100 || got_addr[1] !== 32'h110) begin
         errors++;
         $display("FAIL cold_fill_addrs got n=%0d first=%h expected 2 at 100,110", got_addr.size(),
                  got_addr.size() > 0 ? got_addr[0] : 32'hx);
      end
      fetch(32'h100, 0, 0, 0, 1, 1);
      fetch(32'h108, 0, 0, 0, 1, 1);
      wait_idle("cold_refetch");
   endtask

   task automatic test_bank_cross();
      fetch(32'h200, 0, 0, 0, 0, 0);
      wait_idle("cross_prime");
      got_addr.delete();
      fetch(32'h1F0, 0, 0, 0, 1, 0);
      wait_idle("cross_partial");
      checks++;
      if (got_addr.size() != 1 || got_addr[0] !== 32'h1F0) begin
         errors++;
         $display("FAIL cross_fill_addr got n=%0d first=%h expected 1 at 1f0", got_addr.size(),
                  got_addr.size() > 0 ? got_addr[0] : 32'hx);
      end
      fetch(32'h1F0, 0, 0, 0, 1, 1);
      got_addr.delete();
      fetch(32'hFFFF_FFF0, 0, 0, 0, 0, 0);
      wait_idle("wrap");
      checks++;
      if (got_addr.size() != 2 || got_addr[0] !== 32'h0 || got_addr[1] !== 32'hFFFF_FFF0) begin
         errors++;
         $display("FAIL wrap_fill_addrs got n=%0d first=%h expected 2 at 0,fffffff0", got_addr.size(),
                  got_addr.size() > 0 ? got_addr[0] : 32'hx);
      end
      fetch(32'hFFFF_FFF0, 0, 0, 0, 1, 1);
      wait_idle("wrap_refetch");
   endtask

   task automatic test_uncached();
      got_addr.delete();
      fetch(32'h4000_0010, 1, 0, 0, 0, 0);
      wait_idle("uc");
      checks++;
      if (got_addr.size() != 1 || got_addr[0] !== 32'h4000_0010) begin
         errors++;
         $display("FAIL uc_addr got n=%0d first=%h expected 1 at 40000010", got_addr.size(),
                  got_addr.size() > 0 ? got_addr[0] : 32'hx);
      end
      fetch(32'h4000_0010, 0, 0, 0, 0, 0);
      wait_idle("uc_refetch");
   endtask

   task automatic test_backpressure();
      got_addr.delete();
      mem_req_ready = 1'b0;
      fetch(32'h300, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h300 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL backpressure cycle %0d got valid=%b addr=%h ready=%b expected 1/300/0", i,
                     mem_req_valid, mem_req_addr, req_ready);
         end
      end
      mem_req_ready = 1'b1;
      wait_idle("bp");
      checks++;
      if (got_addr.size() != 2 || got_addr[0] !== 32'h300 || got_addr[1] !== 32'h310) begin
         errors++;
         $display("FAIL bp_addrs got n=%0d first=%h expected 2 at 300,310", got_addr.size(),
                  got_addr.size() > 0 ? got_addr[0] : 32'hx);
      end
   endtask

   task automatic test_invalidate_flush();
      rsp_lat = 4;
      got_addr.delete();
      fetch(32'h540, 0, 0, 0, 0, 0);
      wait_fill_wait("inv");
      invalidate = 1'b1;
      @(posedge clk); #1;
      invalidate = 1'b0;
      wait_idle("inv");
      rsp_lat = 2;
      fetch(32'h540, 0, 0, 0, 0, 1);
      wait_idle("inv_refetch");
      fetch(32'h100, 0, 0, 0, 0, 0);
      wait_idle("inv_old");
      fetch(32'h540, 0, 0, 1, 1, 1);
      fetch(32'h540, 0, 0, 0, 0, 0);
      wait_idle("inv_same_cycle");
      fetch(32'h540, 0, 1, 0, 1, 1);
      fetch(32'h540, 0, 0, 0, 1, 1);
      wait_idle("flush");
   endtask

   task automatic test_reset_midfill();
      fetch(32'h700, 0, 0, 0, 0, 0);
      wait_idle("rst_prime");
      fetch(32'h700, 0, 0, 0, 1, 1);
      hold = 1;
      got_addr.delete();
      fetch(32'h600, 0, 0, 0, 0, 0);
      wait_fill_wait("rst");
      rst = 1'b0;
      #1;
      checks++;
      if ({req_ready, mem_req_valid, rsp_valid} !== 3'b100 || mem_req_addr !== 32'h0) begin
         errors++;
         $display("FAIL rst_midfill got ready/mvalid/rvalid=%b addr=%h expected 100/0",
                  {req_ready, mem_req_valid, rsp_valid}, mem_req_addr);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      inject = 1;
      @(negedge clk); #1;
      inject = 0;
      @(posedge clk); #1;
      checks++;
      if (req_ready !== 1'b1 || mem_req_valid !== 1'b0 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_late_rsp got ready=%b mvalid=%b rvalid=%b expected 1/0/0", req_ready, mem_req_valid, rsp_valid);
      end
      hold = 0;
      fetch(32'h700, 0, 0, 0, 0, 0);
      wait_idle("rst_lookup_a");
      fetch(32'h600, 0, 0, 0, 0, 0);
      wait_idle("rst_lookup_b");
   endtask

   initial begin
      test_reset();
      test_cold_fill();
      test_bank_cross();
      test_uncached();
      test_backpressure();
      test_invalidate_flush();
      test_reset_midfill();
      repeat (4) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
